// File: rtl/dl_pipe_reg.sv
// dl_pipe_reg: elastic pipeline register built from NUM_STAGES chained
// stages, each a 2-entry skid buffer with state-only outputs.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   flush      synchronous discard of all held entries
//   in_valid   upstream word present on in_data
//   in_ready   block accepts in_data this cycle
//   in_data    upstream payload (NUM_BITS)
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to downstream (NUM_BITS)
//   occ        entries held; present only when DL_PIPE_REG_OCC_EN is defined
//
// Optional feature macro: DL_PIPE_REG_OCC_EN (adds occ port and counter).

module dl_pipe_reg #(
    parameter int unsigned          NUM_BITS   = 1,
    parameter int unsigned          NUM_STAGES = 1,
    parameter logic [NUM_BITS-1:0]  RESET_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_data
`ifdef DL_PIPE_REG_OCC_EN
    ,
    output logic [$clog2(2*NUM_STAGES+1)-1:0] occ
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Link k connects stage k-1 (producer) to stage k (consumer).
    // Link 0 is the block input, link NUM_STAGES the block output.
    logic                vld [NUM_STAGES+1];
    logic                rdy [NUM_STAGES+1];
    logic [NUM_BITS-1:0] dat [NUM_STAGES+1];

    assign vld[0]          = in_valid;
    assign dat[0]          = in_data;
    assign in_ready        = rdy[0];
    assign rdy[NUM_STAGES] = out_ready;
    assign out_valid       = vld[NUM_STAGES];
    assign out_data        = dat[NUM_STAGES];

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            state_e              state_q, state_d;
            logic [NUM_BITS-1:0] main_q, main_d;
            logic [NUM_BITS-1:0] skid_q, skid_d;
            logic                i_fire, o_fire;
            logic                st_rdy, st_vld;

            assign i_fire = vld[k] & rdy[k];
            assign o_fire = vld[k+1] & rdy[k+1];

            // Flush empties the stage but leaves data regs untouched,
            // so out_data keeps showing its last value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= EMPTY;
                    main_q  <= RESET_VAL;
                    skid_q  <= RESET_VAL;
                end else if (flush) begin
                    state_q <= EMPTY;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                unique case (state_q)
                    EMPTY: begin
                        if (i_fire) begin
                            state_d = ONE;
                            main_d  = dat[k];
                        end
                    end
                    ONE: begin
                        if (i_fire && o_fire) begin
                            main_d  = dat[k];
                        end else if (i_fire) begin
                            state_d = TWO;
                            skid_d  = dat[k];
                        end else if (o_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (o_fire) begin
                            state_d = ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end

            // Handshake outputs come from state only, which cuts both
            // the data and the ready path at every stage.
            always_comb begin
                st_rdy = (state_q != TWO);
                st_vld = (state_q != EMPTY);
            end

            assign rdy[k]   = st_rdy;
            assign vld[k+1] = st_vld;
            assign dat[k+1] = main_q;
        end
    endgenerate

`ifdef DL_PIPE_REG_OCC_EN
    localparam int unsigned OCC_W = $clog2(2*NUM_STAGES+1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             blk_in_fire, blk_out_fire;

    assign blk_in_fire  = in_valid & in_ready;
    assign blk_out_fire = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (blk_in_fire && !blk_out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!blk_in_fire && blk_out_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dl_pipe_reg.sv
// tb_dl_pipe_reg: directed self-checking bench for dl_pipe_reg
// (NUM_BITS=8, NUM_STAGES=2, RESET_VAL=8'hA5).

module tb_dl_pipe_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef DL_PIPE_REG_OCC_EN
    logic [2:0] occ;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dl_pipe_reg #(
        .NUM_BITS   (8),
        .NUM_STAGES (2),
        .RESET_VAL  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DL_PIPE_REG_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        out_ready = 1'b0;
        for (int c = 0; c < n; c++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(c);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL rst_out_data: got %h want a5", out_data);
        end
`ifdef DL_PIPE_REG_OCC_EN
        n_cmp++;
        if (occ !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_occ: got %0d want 0", occ);
        end
`endif
    endtask

    task automatic test_stream;
        logic [7:0] want;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_data  = 8'(c + 1);
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_in_ready c=%0d: got %b want 1",
                             c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 2 && c < 10) begin
                want = 8'(c - 1);
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== want) begin
                    n_bad++;
                    $display("FAIL stream_out c=%0d: got v=%b d=%h want v=1 d=%h",
                             c, out_valid, out_data, want);
                end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stream_idle c=%0d: got v=%b want 0",
                             c, out_valid);
                end
            end
`ifdef DL_PIPE_REG_OCC_EN
            if (c == 5) begin
                n_cmp++;
                if (occ !== 3'd2) begin
                    n_bad++;
                    $display("FAIL stream_occ: got %0d want 2", occ);
                end
            end
`endif
            tick();
        end
    endtask

    task automatic test_backpressure;
        int         idx;
        int         k;
        logic       acc;
        logic [7:0] want;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(c);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_accept c=%0d: got %b want 1", c, in_ready);
            end
            tick();
        end
        in_data = 8'h14;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_full c=%0d: got %b want 0", c, in_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h10) begin
                n_bad++;
                $display("FAIL bp_hold c=%0d: got v=%b d=%h want v=1 d=10",
                         c, out_valid, out_data);
            end
`ifdef DL_PIPE_REG_OCC_EN
            n_cmp++;
            if (occ !== 3'd4) begin
                n_bad++;
                $display("FAIL bp_occ: got %0d want 4", occ);
            end
`endif
            tick();
        end
        out_ready = 1'b1;
        idx = 4;
        k   = 0;
        for (int c = 0; c < 30 && k < 6; c++) begin
            in_valid = (idx < 6);
            in_data  = 8'h10 + 8'(idx);
            acc      = in_valid && in_ready;
            if (out_valid) begin
                want = 8'h10 + 8'(k);
                n_cmp++;
                if (out_data !== want) begin
                    n_bad++;
                    $display("FAIL bp_order k=%0d: got %h want %h",
                             k, out_data, want);
                end
                k++;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (k != 6 || idx != 6) begin
            n_bad++;
            $display("FAIL bp_timeout: got out=%0d in=%0d want 6 6", k, idx);
        end
    endtask

    task automatic test_back_to_back;
        int         nacc;
        logic       acc;
        logic [7:0] want;
        fill(8'h20, 4);
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'h24 + 8'(nacc);
            want      = 8'h20 + 8'(c);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== want) begin
                n_bad++;
                $display("FAIL b2b_out c=%0d: got v=%b d=%h want v=1 d=%h",
                         c, out_valid, out_data, want);
            end
            if (c == 0) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_full: got %b want 0", in_ready);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready c=%0d: got %b want 1",
                             c, in_ready);
                end
`ifdef DL_PIPE_REG_OCC_EN
                n_cmp++;
                if (occ !== 3'd2) begin
                    n_bad++;
                    $display("FAIL b2b_occ c=%0d: got %0d want 2", c, occ);
                end
`endif
            end
            acc = in_ready;
            tick();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (nacc != 8) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d want 8", nacc);
        end
        for (int c = 0; c < 2; c++) begin
            want = 8'h2A + 8'(c);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== want) begin
                n_bad++;
                $display("FAIL b2b_drain c=%0d: got v=%b d=%h want v=1 d=%h",
                         c, out_valid, out_data, want);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush;
        fill(8'h30, 3);
        in_valid = 1'b1;
        in_data  = 8'h77;
        flush    = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fl_ready_pre: got %b want 1", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fl_empty: got v=%b r=%b want v=0 r=1",
                     out_valid, in_ready);
        end
        n_cmp++;
        if (out_data !== 8'h30) begin
            n_bad++;
            $display("FAIL fl_data_hold: got %h want 30", out_data);
        end
`ifdef DL_PIPE_REG_OCC_EN
        n_cmp++;
        if (occ !== 3'd0) begin
            n_bad++;
            $display("FAIL fl_occ: got %0d want 0", occ);
        end
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h88;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fl_lat1: got v=%b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h88) begin
            n_bad++;
            $display("FAIL fl_next: got v=%b d=%h want v=1 d=88",
                     out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fl_after: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        fill(8'h40, 4);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_full: got %b want 0", in_ready);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_state: got v=%b r=%b want v=0 r=1",
                     out_valid, in_ready);
        end
        n_cmp++;
        if (out_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL rm_data: got %h want a5", out_data);
        end
`ifdef DL_PIPE_REG_OCC_EN
        n_cmp++;
        if (occ !== 3'd0) begin
            n_bad++;
            $display("FAIL rm_occ: got %0d want 0", occ);
        end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rm_lost c=%0d: got v=%b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
